// File: rtl/camera_ray_scanner.sv
// Frame-walking primary ray generator: raster scan of (x, y, sample) feeding a
// stallable 3-stage direction pipeline with a valid/ready output.
package camera_ray_pkg;
    typedef struct packed {
        logic signed [18:0] x;
        logic signed [18:0] y;
        logic signed [18:0] z;
    } vec3_t;

    typedef struct packed {
        vec3_t orig;
        vec3_t dir;
    } ray_t;

    localparam vec3_t point_default = '0;
    localparam logic signed [18:0] NEGATIVE_ONE = -19'sd65536;
endpackage

module camera_ray_scanner
    import camera_ray_pkg::*;
#(
    parameter int          H_RES   = 800,
    parameter int          V_RES   = 600,
    parameter int          SPP     = 4,
    parameter int          FRAC    = 16,
    parameter int unsigned SCALE_X = 193,
    parameter int unsigned SCALE_Y = 193,
    parameter int          SHIFT_X = 77321,
    parameter int          SHIFT_Y = 57991,
    parameter logic [15:0] SEED_X  = 16'h1ACE,
    parameter logic [15:0] SEED_Y  = 16'hC0DE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       jitter_en,
    output logic       busy,
    output logic       frame_done,
    output logic       ray_valid,
    input  logic       ray_ready,
    output ray_t       ray_out,
    output logic [9:0] ray_px,
    output logic [9:0] ray_py,
    output logic [3:0] ray_sample,
    output logic       ray_last
);

    localparam int CW = 10 + FRAC;
    localparam int PW = CW + 32;
    localparam logic [FRAC-1:0] CENTRE = {1'b1, {(FRAC-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t     state_reg;
    logic [9:0] x_reg, y_reg, x_next, y_next;
    logic [3:0] s_reg, s_next;
    logic       jitter_reg;

    logic       s1_valid_reg, s1_last_reg;
    logic [9:0] s1_px_reg, s1_py_reg;
    logic [3:0] s1_s_reg;
    logic       s2_valid_reg, s2_last_reg;
    logic [9:0] s2_px_reg, s2_py_reg;
    logic [3:0] s2_s_reg;

    logic       adv, inject, jit, at_max, accept_last;
    logic [9:0] pix [2];
    logic signed [18:0] dir_next [2];

    // 16-bit xorshift with the (7, 9, 8) triple: full period over nonzero states.
    function automatic logic [15:0] xorshift16(input logic [15:0] v);
        logic [15:0] t;
        t = v ^ (v << 7);
        t = t ^ (t >> 9);
        t = t ^ (t << 8);
        return t;
    endfunction

    assign adv         = ~(ray_valid & ~ray_ready);
    // The start cycle itself injects pixel (0,0,0), giving a 3-cycle start-to-valid latency.
    assign inject      = adv & ((state_reg == ISSUE) | ((state_reg == IDLE) & start));
    assign jit         = (state_reg == IDLE) ? jitter_en : jitter_reg;
    assign at_max      = (x_reg == 10'(H_RES - 1)) && (y_reg == 10'(V_RES - 1)) && (s_reg == 4'(SPP - 1));
    assign accept_last = ray_valid & ray_ready & ray_last;
    assign pix[0]      = x_reg;
    assign pix[1]      = y_reg;

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        s_next = s_reg;
        if (s_reg == 4'(SPP - 1)) begin
            s_next = '0;
            if (x_reg == 10'(H_RES - 1)) begin
                x_next = '0;
                y_next = (y_reg == 10'(V_RES - 1)) ? 10'd0 : y_reg + 10'd1;
            end else begin
                x_next = x_reg + 10'd1;
            end
        end else begin
            s_next = s_reg + 4'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [15:0] SEED  = (gi == 0) ? SEED_X : SEED_Y;
            localparam int unsigned SCALE = (gi == 0) ? SCALE_X : SCALE_Y;
            localparam int          SHIFT = (gi == 0) ? SHIFT_X : SHIFT_Y;

            logic [15:0]     prng_reg;
            logic [CW-1:0]   coord_reg;
            logic [PW-1:0]   prod_reg;
            logic [FRAC-1:0] offset;

            assign offset = jit ? prng_reg[FRAC-1:0] : CENTRE;

            // PRNG steps only on injection and reseeds at frame end, so every frame
            // draws the same offsets regardless of stalls or idle time.
            always_ff @(posedge clk) begin
                if (rst) begin
                    prng_reg  <= SEED;
                    coord_reg <= '0;
                    prod_reg  <= '0;
                end else begin
                    if (accept_last) begin
                        prng_reg <= SEED;
                    end else if (inject) begin
                        prng_reg <= xorshift16(prng_reg);
                    end
                    if (adv) begin
                        coord_reg <= {pix[gi], offset};
                        prod_reg  <= PW'(coord_reg) * PW'(SCALE);
                    end
                end
            end

            assign dir_next[gi] = 19'((prod_reg >> FRAC) - PW'(SHIFT));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            x_reg        <= '0;
            y_reg        <= '0;
            s_reg        <= '0;
            jitter_reg   <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_px_reg    <= '0;
            s1_py_reg    <= '0;
            s1_s_reg     <= '0;
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_px_reg    <= '0;
            s2_py_reg    <= '0;
            s2_s_reg     <= '0;
            ray_valid    <= 1'b0;
            ray_last     <= 1'b0;
            ray_px       <= '0;
            ray_py       <= '0;
            ray_sample   <= '0;
            ray_out      <= '0;
        end else begin
            frame_done <= 1'b0;

            if (adv) begin
                s1_valid_reg <= inject;
                s1_last_reg  <= inject & at_max;
                s1_px_reg    <= x_reg;
                s1_py_reg    <= y_reg;
                s1_s_reg     <= s_reg;

                s2_valid_reg <= s1_valid_reg;
                s2_last_reg  <= s1_last_reg;
                s2_px_reg    <= s1_px_reg;
                s2_py_reg    <= s1_py_reg;
                s2_s_reg     <= s1_s_reg;

                ray_valid    <= s2_valid_reg;
                ray_last     <= s2_last_reg;
                ray_px       <= s2_px_reg;
                ray_py       <= s2_py_reg;
                ray_sample   <= s2_s_reg;
                ray_out.orig <= point_default;
                ray_out.dir.x <= dir_next[0];
                ray_out.dir.y <= dir_next[1];
                ray_out.dir.z <= NEGATIVE_ONE;
            end

            if (inject) begin
                x_reg <= x_next;
                y_reg <= y_next;
                s_reg <= s_next;
            end

            case (state_reg)
                IDLE: begin
                    if (start && adv) begin
                        jitter_reg <= jitter_en;
                        busy       <= 1'b1;
                        state_reg  <= at_max ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (inject && at_max) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept_last) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_ray_scanner.sv
// Directed bench for camera_ray_scanner on a 4x2 frame with 2 samples per pixel.
module tb_camera_ray_scanner;
    import camera_ray_pkg::*;

    localparam int H = 4;
    localparam int V = 2;
    localparam int S = 2;
    localparam int N = H * V * S;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       jitter_en;
    logic       ray_ready;
    logic       busy;
    logic       frame_done;
    logic       ray_valid;
    ray_t       ray_out;
    logic [9:0] ray_px;
    logic [9:0] ray_py;
    logic [3:0] ray_sample;
    logic       ray_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    camera_ray_scanner #(.H_RES(H), .V_RES(V), .SPP(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .jitter_en  (jitter_en),
        .busy       (busy),
        .frame_done (frame_done),
        .ray_valid  (ray_valid),
        .ray_ready  (ray_ready),
        .ray_out    (ray_out),
        .ray_px     (ray_px),
        .ray_py     (ray_py),
        .ray_sample (ray_sample),
        .ray_last   (ray_last)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] xs(input logic [15:0] v);
        logic [15:0] t;
        t = v ^ (v << 7);
        t = t ^ (t >> 9);
        t = t ^ (t << 8);
        return t;
    endfunction

    // Reference direction: ((pix + off/2^16) * 193/2^16) in Q16, minus the half-sensor shift.
    function automatic longint exp_dir(input int pix, input int off, input int shift);
        longint c;
        c = (longint'(pix) << 16) | longint'(off);
        return ((c * 193) >> 16) - longint'(shift);
    endfunction

    task automatic check_ray(input int k, input bit jit, input logic [15:0] ox, input logic [15:0] oy, input string tag);
        int es, ex, ey, offx, offy;
        string t;
        es   = k % S;
        ex   = (k / S) % H;
        ey   = k / (S * H);
        offx = jit ? int'(ox) : 32768;
        offy = jit ? int'(oy) : 32768;
        t    = $sformatf("%s[%0d]", tag, k);
        $display("ray %s px=%0d py=%0d s=%0d last=%0b dx=%0d dy=%0d", t, ray_px, ray_py, ray_sample, ray_last,
                 ray_out.dir.x, ray_out.dir.y);
        chk({t, " valid"},  64'(ray_valid), 64'(1));
        chk({t, " px"},     64'(ray_px), 64'(ex));
        chk({t, " py"},     64'(ray_py), 64'(ey));
        chk({t, " sample"}, 64'(ray_sample), 64'(es));
        chk({t, " last"},   64'(ray_last), 64'(k == N - 1));
        chk({t, " dx"},     64'(ray_out.dir.x), 64'(exp_dir(ex, offx, 77321)));
        chk({t, " dy"},     64'(ray_out.dir.y), 64'(exp_dir(ey, offy, 57991)));
        chk({t, " dz"},     64'(ray_out.dir.z), -64'sd65536);
        chk({t, " orig"},   64'(ray_out.orig === '0), 64'(1));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [15:0] mx, my;
        ray_t        snap;
        logic [9:0]  snap_px, snap_py;
        logic [3:0]  snap_s;
        bit          stalled;
        int          k, cyc, seen, cnt;

        rst = 1'b1; start = 1'b0; jitter_en = 1'b0; ray_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and a quiet idle period.
        chk("rst valid",  64'(ray_valid), 64'(0));
        chk("rst busy",   64'(busy), 64'(0));
        chk("rst done",   64'(frame_done), 64'(0));
        chk("rst last",   64'(ray_last), 64'(0));
        chk("rst tags",   64'({ray_px, ray_py, ray_sample}), 64'(0));
        chk("rst ray",    64'(ray_out === '0), 64'(1));
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (ray_valid || busy || frame_done) seen++;
        end
        chk("idle quiet", 64'(seen), 64'(0));

        // Unstalled centred frame: latency, order, hand-computed directions, end of frame.
        jitter_en = 1'b0;
        pulse_start();
        chk("lat busy", 64'(busy), 64'(1));
        chk("lat c1",   64'(ray_valid), 64'(0));
        @(negedge clk);
        chk("lat c2",   64'(ray_valid), 64'(0));
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check_ray(i, 1'b0, 16'h0, 16'h0, "ctr");
            chk($sformatf("ctr[%0d] busy", i), 64'(busy), 64'(1));
            if (i == 0) begin
                chk("hand dx(0,0)", 64'(ray_out.dir.x), -64'sd77225);
                chk("hand dy(0,0)", 64'(ray_out.dir.y), -64'sd57895);
            end
            if (i == 6) chk("hand dx(3,0)", 64'(ray_out.dir.x), -64'sd76646);
            if (i == 8) chk("hand dy(0,1)", 64'(ray_out.dir.y), -64'sd57702);
            @(negedge clk);
        end
        chk("ctr done",   64'(frame_done), 64'(1));
        chk("ctr busy0",  64'(busy), 64'(0));
        chk("ctr valid0", 64'(ray_valid), 64'(0));
        @(negedge clk);
        chk("ctr done1", 64'(frame_done), 64'(0));

        // Jittered frame with random backpressure; jitter_en drops right after start.
        mx = 16'h1ACE; my = 16'hC0DE;
        k = 0; cyc = 0; stalled = 1'b0; seen = 0;
        snap = '0; snap_px = '0; snap_py = '0; snap_s = '0;
        jitter_en = 1'b1;
        pulse_start();
        jitter_en = 1'b0;
        while (k < N && cyc < 2000) begin
            if (stalled) begin
                chk("stall valid", 64'(ray_valid), 64'(1));
                chk("stall dx",    64'(ray_out.dir.x), 64'(snap.dir.x));
                chk("stall dy",    64'(ray_out.dir.y), 64'(snap.dir.y));
                chk("stall tags",  64'({ray_px, ray_py, ray_sample}), 64'({snap_px, snap_py, snap_s}));
            end
            ray_ready = ($urandom_range(0, 9) < 3);
            stalled = 1'b0;
            if (ray_valid) begin
                if (ray_ready) begin
                    check_ray(k, 1'b1, mx, my, "jit");
                    mx = xs(mx);
                    my = xs(my);
                    k++;
                end else begin
                    stalled = 1'b1;
                    snap = ray_out; snap_px = ray_px; snap_py = ray_py; snap_s = ray_sample;
                end
            end
            if (frame_done) seen++;
            @(negedge clk);
            cyc++;
        end
        chk("jit count", 64'(k), 64'(N));
        ray_ready = 1'b1;
        chk("jit done",  64'(frame_done), 64'(1));
        chk("jit early", 64'(seen), 64'(0));
        chk("jit busy0", 64'(busy), 64'(0));

        // Start pulsed mid-frame must be ignored.
        @(negedge clk);
        cnt = 0; cyc = 0; seen = 0;
        pulse_start();
        while (seen == 0 && cyc < 200) begin
            if (frame_done) seen = 1;
            else begin
                if (ray_valid && ray_ready) cnt++;
                start = (cyc == 6);
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk("restart done",  64'(seen), 64'(1));
        chk("restart count", 64'(cnt), 64'(N));
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (ray_valid || busy) seen++;
        end
        chk("restart quiet", 64'(seen), 64'(0));

        // Reset mid-frame, then a fresh start reproduces the seeded jitter sequence.
        jitter_en = 1'b1;
        pulse_start();
        cyc = 0;
        while (!(ray_valid && ray_sample == 4'd1 && ray_px == 10'd2) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid valid", 64'(ray_valid), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("abort valid", 64'(ray_valid), 64'(0));
        chk("abort busy",  64'(busy), 64'(0));
        chk("abort done",  64'(frame_done), 64'(0));
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (frame_done || ray_valid) seen++;
        end
        chk("abort quiet", 64'(seen), 64'(0));
        mx = 16'h1ACE; my = 16'hC0DE;
        pulse_start();
        jitter_en = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check_ray(i, 1'b1, mx, my, "rerun");
            mx = xs(mx);
            my = xs(my);
            @(negedge clk);
        end
        chk("rerun done", 64'(frame_done), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
